// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - single-clock FIFO with registered read port, exact count and sticky error flags
module fifo_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      inp_data,
    input  logic                       push,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside a pop.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL_COUNT) || pop);

    // Status flags come straight from the registered count, never from the pointers.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);

    // Storage array; not reset, old contents become unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= inp_data;
        end
    end

    // Pointers, occupancy and the registered read port; reading before the write gives old data when full.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pop_ok;
            if (pop_ok) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky debug flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_queue.md
# fifo_queue

- Single-clock first-in-first-out queue, the counterpart to the LIFO stack.
- Words leave from the opposite end to the one they entered, in arrival order.
- Used between pipeline stages of the polynomial/NTT datapath where coefficient order must be preserved.
- Registered read port, exact occupancy count, and sticky overflow/underflow flags for debug.

## Interface
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 32, number of entries; must be a power of two, at least 2.
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- inp_data  input  DATA_WIDTH  word to enqueue; sampled when push is accepted.
- push  input  1  enqueue request.
- pop  input  1  dequeue request.
- out_data  output  DATA_WIDTH  last dequeued word (registered); holds its value until the next accepted pop.
- out_valid  output  1  one-cycle pulse: out_data updated this cycle.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a push was rejected; cleared only by reset.
- underflow  output  1  sticky flag: a pop was rejected; cleared only by reset.

## Operation
- Storage is a DEPTH x DATA_WIDTH array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH; they have no extra wrap bit.
  - Full and empty are derived from count only, never from pointer comparison.
- Push acceptance: push=1 and either the queue is not full, or it is full and pop=1 in the same cycle.
  - When accepted: mem[wr_ptr] <= inp_data, then wr_ptr increments.
- Pop acceptance: pop=1 and the queue is not empty.
  - When accepted: out_data <= mem[rd_ptr], rd_ptr increments, out_valid <= 1.
  - When not accepted: out_valid <= 0 and out_data holds its value.
- count update:
  - +1 if only push is accepted.
  - -1 if only pop is accepted.
  - Unchanged if both or neither are accepted.
- Rejected push (push=1 while full, pop=0): no state change except overflow <= 1.
- Rejected pop (pop=1 while empty): no state change except underflow <= 1.
- Simultaneous push+pop:
  - Empty: push accepted; pop rejected and sets underflow; count becomes 1.
  - Full: both accepted; count stays DEPTH. rd_ptr == wr_ptr here, so the read returns the OLD word (read-before-write).
  - Otherwise: both accepted.
- An accepted pop never returns a word pushed in the same cycle.
- Reset, including mid-operation:
  - Pointers and count go to 0; all flags clear.
  - Previous contents are discarded (the array itself is not cleared, but it is unreachable).
  - push/pop in the reset cycle are ignored.

## Timing
- Reset values:
  - out_data = 0, out_valid = 0, count = 0
  - fifo_empty = 1, fifo_full = 0
  - overflow = 0, underflow = 0
- Push latency: a word pushed in cycle N is visible in count and fifo_empty after edge N, and can be popped in cycle N+1.
- Pop latency: out_data and out_valid are valid the cycle after the pop request (registered, 1-cycle).
- fifo_empty, fifo_full and count are registered and reflect all pushes and pops accepted up to the previous edge.
- Throughput: one push and one pop per cycle, sustained indefinitely when occupancy is between 1 and DEPTH-1.
- No combinational path from push/pop/inp_data to any output.

## Test plan
- Reset check: assert reset for 2 cycles with push=pop=1 -> count=0, fifo_empty=1, out_valid=0, out_data=0, flags=0.
- Order and latency (DEPTH=32): push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 cycles.
  - out_data = 0x11, 0x22, 0x33, each one cycle after its pop.
  - out_valid high for exactly those 3 cycles.
  - count goes 1, 2, 3, 2, 1, 0.
- Full/overflow and wrap (DEPTH=4):
  - Push 0xA0..0xA3 -> fifo_full=1, count=4.
  - Push 0xFF -> overflow=1, count stays 4.
  - Pop 4 -> out_data 0xA0..0xA3, never 0xFF.
  - Push 0xB0..0xB5 interleaved with pops (pointers wrap) -> output order is preserved.
- Empty/underflow: pop on an empty queue -> underflow=1, out_valid=0, out_data unchanged, count=0. Underflow remains 1 after 10 idle cycles.
- Simultaneous events (DEPTH=4):
  - Empty + push 0x55 + pop -> count=1, underflow=1; the next pop returns 0x55.
  - Full with 0xC0..0xC3, then push 0xD0 + pop -> out_data=0xC0, count=4. Draining gives 0xC1, 0xC2, 0xC3, 0xD0.
- Reset mid-operation: with 3 entries queued, assert reset for 1 cycle, then push 0x77 and pop -> out_data=0x77; stale entries never appear.
